// File: rtl/led_frame_sequencer_pkg.sv
// Shared types and default timing constants for the LED frame sequencer family.
// FSM state encodings and the registered output flag bundle live here.
package led_frame_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_WAIT   = 3'd2,
    ST_LATCH  = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_t;

  // WS2812 strip defaults: 50 us reset gap at 12 MHz, 150-pixel strip.
  localparam int LATCH_CYCLES_WS2812 = 600;
  localparam int FRAME_LEDS          = 150;

  typedef struct packed {
    logic selected;
    logic busy;
    logic done;
    logic error;
    logic overrun;
  } seq_flags_t;

  function automatic logic is_busy_state(input seq_state_t s);
    return s inside {ST_SELECT, ST_WAIT, ST_LATCH};
  endfunction

endpackage

// File: rtl/led_frame_sequencer_rising_edge_detect.sv
// Rising-edge detector: registered previous level, combinational one-cycle pulse.
// Shared by the LED actor blocks that react to level strobes.
module rising_edge_detect (
  input  logic clock_12mhz,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev_level;

  always_ff @(posedge clock_12mhz) begin
    if (reset) prev_level <= 1'b0;
    else       prev_level <= level;
  end

  assign rise = level & ~prev_level;

endmodule

// File: rtl/led_frame_sequencer.sv
// Walks every LED of a strip once per frame-rate edge, handshaking each LED with
// the bit encoder, then holds the strip latch gap and pulses done.
module led_frame_sequencer
  import led_frame_sequencer_pkg::*;
#(
  parameter int NUM_LEDS       = FRAME_LEDS,
  parameter int IDX_W          = 8,
  parameter int REVERSE        = 0,
  parameter int LATCH_CYCLES   = LATCH_CYCLES_WS2812,
  parameter int TIMEOUT_CYCLES = 4095,
  parameter int CNT_W          = 12
) (
  input  logic             clock_12mhz,
  input  logic             reset,
  input  logic             framerate,
  input  logic             encoder_finished,
  output logic [IDX_W-1:0] led_index,
  output logic             led_selected,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             overrun
);

  localparam logic [IDX_W-1:0] FIRST = (REVERSE != 0) ? IDX_W'(NUM_LEDS - 1) : '0;
  localparam logic [IDX_W-1:0] LAST  = (REVERSE != 0) ? '0 : IDX_W'(NUM_LEDS - 1);
  localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_d;
  seq_flags_t       flags_q, flags_d;
  logic             start;
  logic             timeout;

  rising_edge_detect u_frame_edge (
    .clock_12mhz (clock_12mhz),
    .reset       (reset),
    .level       (framerate),
    .rise        (start)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = led_index;
    timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SELECT;
          idx_d   = FIRST;
        end
      end
      ST_SELECT: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (encoder_finished) begin
          if (led_index == LAST) begin
            cnt_d   = LATCH_LOAD;
            state_d = ST_LATCH;
          end else begin
            idx_d   = (REVERSE != 0) ? led_index - 1'b1 : led_index + 1'b1;
            state_d = ST_SELECT;
          end
        end else begin
          // cnt_q counts elapsed WAIT cycles; this edge takes it to TIMEOUT_CYCLES.
          cnt_d = cnt_q + 1'b1;
          if ((TIMEOUT_CYCLES > 0) && (cnt_q == TMO_LAST)) begin
            timeout = 1'b1;
            idx_d   = FIRST;
            state_d = ST_IDLE;
          end
        end
      end
      ST_LATCH: begin
        if (cnt_q == '0) begin
          idx_d   = FIRST;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Flags are decoded from the next state so every output is a plain register.
  always_comb begin
    flags_d          = '0;
    flags_d.selected = (state_d == ST_SELECT);
    flags_d.busy     = is_busy_state(state_d);
    flags_d.done     = (state_d == ST_DONE);
    flags_d.error    = timeout;
    flags_d.overrun  = start && (state_q != ST_IDLE);
  end

  always_ff @(posedge clock_12mhz) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      led_index <= FIRST;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      led_index <= idx_d;
      flags_q   <= flags_d;
    end
  end

  assign led_selected = flags_q.selected;
  assign busy         = flags_q.busy;
  assign done         = flags_q.done;
  assign error        = flags_q.error;
  assign overrun      = flags_q.overrun;

endmodule
